// File: rtl/call_frame_ctl_pkg.sv
// Shared encodings for the call-frame controller: decoder commands, error
// codes, FSM state encodings, and the operand-stack op/status codes.
// Also provides the helper that maps a stack status to a controller error.
package call_frame_ctl_pkg;

  localparam int unsigned CMD_W   = 3;
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned STAT_W  = 3;
  localparam int unsigned STATE_W = 2;

  // Decoder commands
  localparam logic [CMD_W-1:0] CMD_PUSH      = 3'd0;
  localparam logic [CMD_W-1:0] CMD_CALL      = 3'd1;
  localparam logic [CMD_W-1:0] CMD_RETURN    = 3'd2;
  localparam logic [CMD_W-1:0] CMD_LOCAL_GET = 3'd3;
  localparam logic [CMD_W-1:0] CMD_LOCAL_SET = 3'd4;

  // Completion error codes
  localparam logic [ERR_W-1:0] ERR_NONE            = 3'd0;
  localparam logic [ERR_W-1:0] ERR_FRAME_OVERFLOW  = 3'd1;
  localparam logic [ERR_W-1:0] ERR_FRAME_UNDERFLOW = 3'd2;
  localparam logic [ERR_W-1:0] ERR_ARITY           = 3'd3;
  localparam logic [ERR_W-1:0] ERR_BAD_LOCAL       = 3'd4;
  localparam logic [ERR_W-1:0] ERR_STACK           = 3'd5;

  // FSM states
  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_EXEC    = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESTORE = 2'd2;
  localparam logic [STATE_W-1:0] ST_CHECK   = 2'd3;

  // Operand-stack opcodes
  localparam logic [OP_W-1:0] STK_OP_NONE                 = 3'd0;
  localparam logic [OP_W-1:0] STK_OP_PUSH                 = 3'd1;
  localparam logic [OP_W-1:0] STK_OP_POP                  = 3'd2;
  localparam logic [OP_W-1:0] STK_OP_INDEX_RESET          = 3'd3;
  localparam logic [OP_W-1:0] STK_OP_INDEX_RESET_AND_PUSH = 3'd4;
  localparam logic [OP_W-1:0] STK_OP_UNDERFLOW_GET        = 3'd5;
  localparam logic [OP_W-1:0] STK_OP_UNDERFLOW_SET        = 3'd6;

  // Operand-stack status codes
  localparam logic [STAT_W-1:0] STK_OK         = 3'd0;
  localparam logic [STAT_W-1:0] STK_OVERFLOW   = 3'd1;
  localparam logic [STAT_W-1:0] STK_UNDERFLOW  = 3'd2;
  localparam logic [STAT_W-1:0] STK_BAD_OFFSET = 3'd3;

  // Map the stack status seen in CHECK to the error reported for a command.
  function automatic logic [ERR_W-1:0] status_to_err(input logic [CMD_W-1:0]  c,
                                                     input logic [STAT_W-1:0] s);
    logic [ERR_W-1:0] e;
    e = ERR_STACK;
    if (s == STK_OK) begin
      e = ERR_NONE;
    end else if ((c == CMD_LOCAL_GET || c == CMD_LOCAL_SET) && s == STK_BAD_OFFSET) begin
      e = ERR_BAD_LOCAL;
    end
    return e;
  endfunction

endpackage

// File: rtl/call_frame_ctl_mem.sv
// Frame stack storage: ENTRIES x DW register array, synchronous write,
// combinational read (the top module reads the current top entry).
// Ports: clk_i, wr_en_i/wr_addr_i/wr_data_i write port; rd_addr_i -> rd_data_o.
module call_frame_mem #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned DW      = 32
) (
  input  logic          clk_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [ENTRIES];

  // Entries are only read after being written, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/call_frame_ctl.sv
// Call-frame controller in front of the operand stack. Accepts PUSH / CALL /
// RETURN / LOCAL_GET / LOCAL_SET over cmd_valid/cmd_ready, keeps a private
// frame stack {return pc, underflow_limit, base_limit} and moves the stack's
// limit window on calls/returns so parameters become locals.
// Ports:
//   clk, reset (async, active-high)
//   cmd_valid/cmd_ready, cmd, cmd_arity, cmd_offset, cmd_data, cmd_pc : decoder side
//   done, err, rdata, ret_pc, frame_depth                              : completion
//   stk_op, stk_data, stk_offset, stk_underflow_limit, stk_base_limit  : to stack
//   stk_index, stk_out, stk_status                                     : from stack
module call_frame_ctl
  import call_frame_ctl_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 7,
  parameter int unsigned FRAMES   = 4,
  parameter int unsigned PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd,
  input  logic [DEPTH:0]      cmd_arity,
  input  logic [DEPTH:0]      cmd_offset,
  input  logic [WIDTH-1:0]    cmd_data,
  input  logic [PC_WIDTH-1:0] cmd_pc,
  output logic                done,
  output logic [2:0]          err,
  output logic [WIDTH-1:0]    rdata,
  output logic [PC_WIDTH-1:0] ret_pc,
  output logic [FRAMES:0]     frame_depth,
  output logic [2:0]          stk_op,
  output logic [WIDTH-1:0]    stk_data,
  output logic [DEPTH:0]      stk_offset,
  output logic [DEPTH:0]      stk_underflow_limit,
  output logic [DEPTH:0]      stk_base_limit,
  input  logic [DEPTH:0]      stk_index,
  input  logic [WIDTH-1:0]    stk_out,
  input  logic [2:0]          stk_status
);

  localparam int unsigned LW  = DEPTH + 1;
  localparam int unsigned FW  = FRAMES + 1;
  localparam int unsigned AW  = FRAMES;
  localparam int unsigned NFR = 1 << FRAMES;
  localparam int unsigned EW  = PC_WIDTH + 2 * LW;

  logic [STATE_W-1:0]  state_q,   state_d;
  logic [CMD_W-1:0]    cmd_q,     cmd_d;
  logic [ERR_W-1:0]    pend_q,    pend_d;
  logic [FW-1:0]       fp_q,      fp_d;
  logic [LW-1:0]       ulim_q,    ulim_d;
  logic [LW-1:0]       blim_q,    blim_d;
  logic [OP_W-1:0]     op_q,      op_d;
  logic [WIDTH-1:0]    sdata_q,   sdata_d;
  logic [LW-1:0]       soff_q,    soff_d;
  logic                done_q,    done_d;
  logic [ERR_W-1:0]    err_q,     err_d;
  logic [WIDTH-1:0]    rdata_q,   rdata_d;
  logic [PC_WIDTH-1:0] ret_pc_q,  ret_pc_d;
  logic                ready_q,   ready_d;

  logic                fr_we;
  logic [AW-1:0]       fr_waddr;
  logic [AW-1:0]       fr_raddr;
  logic [EW-1:0]       fr_wdata;
  logic [EW-1:0]       fr_rdata;
  logic [PC_WIDTH-1:0] fr_pc;
  logic [LW-1:0]       fr_ulim;
  logic [LW-1:0]       fr_blim;
  logic                accept;
  logic                frame_full;
  logic                frame_empty;
  logic                call_short;
  logic                ret_bad_arity;

  // Frame stack: written at fp, top entry lives at fp-1.
  assign fr_waddr = AW'(fp_q);
  assign fr_raddr = AW'(fp_q - FW'(1));
  assign fr_wdata = {cmd_pc, ulim_q, blim_q};
  assign fr_pc    = fr_rdata[EW-1 -: PC_WIDTH];
  assign fr_ulim  = fr_rdata[2*LW-1 -: LW];
  assign fr_blim  = fr_rdata[LW-1:0];

  call_frame_mem #(
    .ENTRIES (NFR),
    .AW      (AW),
    .DW      (EW)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (fr_we),
    .wr_addr_i (fr_waddr),
    .wr_data_i (fr_wdata),
    .rd_addr_i (fr_raddr),
    .rd_data_o (fr_rdata)
  );

  assign accept      = cmd_valid && ready_q;
  assign frame_full  = (fp_q == FW'(NFR));
  assign frame_empty = (fp_q == '0);

  // Not enough operands above the current window for the call's parameters;
  // done as "index < ulim + arity" in one extra bit so nothing wraps.
  assign call_short = ({1'b0, stk_index} < ({1'b0, ulim_q} + {1'b0, cmd_arity}));

  // A result count above 1 is never legal; 1 needs a value above the window.
  assign ret_bad_arity = (cmd_arity > LW'(1)) ||
                         ((cmd_arity == LW'(1)) && (stk_index == ulim_q));

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    pend_d   = pend_q;
    fp_d     = fp_q;
    ulim_d   = ulim_q;
    blim_d   = blim_q;
    op_d     = STK_OP_NONE;
    sdata_d  = sdata_q;
    soff_d   = soff_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    ret_pc_d = ret_pc_q;
    fr_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Pre-checks and the EXEC-cycle stack command are resolved here so
          // they are registered and stable for the whole EXEC cycle.
          state_d = ST_EXEC;
          cmd_d   = cmd;
          pend_d  = ERR_NONE;
          case (cmd)
            CMD_PUSH: begin
              op_d    = STK_OP_PUSH;
              sdata_d = cmd_data;
            end
            CMD_CALL: begin
              if (frame_full) begin
                pend_d = ERR_FRAME_OVERFLOW;
              end else if (call_short) begin
                pend_d = ERR_ARITY;
              end else begin
                fr_we  = 1'b1;
                fp_d   = fp_q + FW'(1);
                blim_d = stk_index - cmd_arity;
                ulim_d = stk_index;
              end
            end
            CMD_RETURN: begin
              if (frame_empty) begin
                pend_d = ERR_FRAME_UNDERFLOW;
              end else if (ret_bad_arity) begin
                pend_d = ERR_ARITY;
              end else begin
                soff_d  = blim_q;
                sdata_d = stk_out;
                op_d    = (cmd_arity == LW'(1)) ? STK_OP_INDEX_RESET_AND_PUSH
                                                : STK_OP_INDEX_RESET;
              end
            end
            CMD_LOCAL_GET: begin
              op_d   = STK_OP_UNDERFLOW_GET;
              soff_d = cmd_offset;
            end
            CMD_LOCAL_SET: begin
              op_d    = STK_OP_UNDERFLOW_SET;
              soff_d  = cmd_offset;
              sdata_d = cmd_data;
            end
            default: ;
          endcase
        end
      end

      ST_EXEC: begin
        // RETURN always takes the RESTORE cycle so its latency is fixed,
        // but only pops the frame when the pre-checks passed.
        if (cmd_q == CMD_RETURN) begin
          state_d = ST_RESTORE;
          if (pend_q == ERR_NONE) begin
            fp_d     = fp_q - FW'(1);
            ulim_d   = fr_ulim;
            blim_d   = fr_blim;
            ret_pc_d = fr_pc;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end

      ST_RESTORE: begin
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (pend_q != ERR_NONE) begin
          err_d = pend_q;
        end else begin
          err_d = status_to_err(cmd_q, stk_status);
          if (cmd_q == CMD_LOCAL_GET && stk_status == STK_OK) begin
            rdata_d = stk_out;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= CMD_PUSH;
      pend_q   <= ERR_NONE;
      fp_q     <= '0;
      ulim_q   <= '0;
      blim_q   <= '0;
      op_q     <= STK_OP_NONE;
      sdata_q  <= '0;
      soff_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= ERR_NONE;
      rdata_q  <= '0;
      ret_pc_q <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      pend_q   <= pend_d;
      fp_q     <= fp_d;
      ulim_q   <= ulim_d;
      blim_q   <= blim_d;
      op_q     <= op_d;
      sdata_q  <= sdata_d;
      soff_q   <= soff_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      ret_pc_q <= ret_pc_d;
      ready_q  <= ready_d;
    end
  end

  assign cmd_ready           = ready_q;
  assign done                = done_q;
  assign err                 = err_q;
  assign rdata               = rdata_q;
  assign ret_pc              = ret_pc_q;
  assign frame_depth         = fp_q;
  assign stk_op              = op_q;
  assign stk_data            = sdata_q;
  assign stk_offset          = soff_q;
  assign stk_underflow_limit = ulim_q;
  assign stk_base_limit      = blim_q;

endmodule
